// File: rtl/alu_pkg.sv
// Shared definitions for the execution-stage ALU: opcode encodings from ALU control,
// FSM state encoding and default datapath width.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [3:0] ALU_AND      = 4'b0000;
  localparam logic [3:0] ALU_OR       = 4'b0001;
  localparam logic [3:0] ALU_NOR      = 4'b0010;
  localparam logic [3:0] ALU_ADD      = 4'b0011;
  localparam logic [3:0] ALU_SUB      = 4'b0100;
  localparam logic [3:0] ALU_NOP      = 4'b1000;
  localparam logic [3:0] ALU_INC      = 4'b1001;
  localparam logic [3:0] ALU_MULTPLUS = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_multiplier.sv
// Iterative shift-add multiplier: one partial-product accumulation per step,
// low WIDTH bits of the product are kept.
module shift_add_multiplier #(
  parameter int WIDTH     = 32,
  parameter int MUL_STEPS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplier_in,
  output logic             last,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(MUL_STEPS);

  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
  logic [CW-1:0]    counter_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      counter_q <= '0;
    end else if (load) begin
      mcand_q   <= mcand_in;
      mplier_q  <= mplier_in;
      acc_q     <= '0;
      counter_q <= '0;
    end else if (step) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q   <= mcand_q << 1;
      mplier_q  <= mplier_q >> 1;
      counter_q <= counter_q + 1'b1;
    end
  end

  // Sampled before the increment, so this is true on the final step's edge.
  assign last    = (counter_q == CW'(MUL_STEPS - 1));
  assign product = acc_q;

endmodule

// File: rtl/multicycle_alu.sv
// Execution-stage ALU: single-cycle logic/arithmetic ops plus a multi-cycle
// MULTPLUS ((A*B) + A) that holds busy while the shift-add multiplier iterates.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH     = alu_pkg::WIDTH,
  parameter int MUL_STEPS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] addend_q, addend_d;
  logic             zero_q, done_q, done_d;
  logic             mul_load, mul_step, mul_last;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] single_result;

  shift_add_multiplier #(
    .WIDTH     (WIDTH),
    .MUL_STEPS (MUL_STEPS)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .load      (mul_load),
    .step      (mul_step),
    .mcand_in  (A),
    .mplier_in (B),
    .last      (mul_last),
    .product   (mul_product)
  );

  always_comb begin
    single_result = '0;
    case (ALUOperation)
      ALU_AND: single_result = A & B;
      ALU_OR:  single_result = A | B;
      ALU_NOR: single_result = ~(A | B);
      ALU_ADD: single_result = A + B;
      ALU_SUB: single_result = A - B;
      ALU_INC: single_result = A + 1'b1;
      default: single_result = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    addend_d = addend_q;
    done_d   = 1'b0;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (ALUOperation == ALU_MULTPLUS) begin
            mul_load = 1'b1;
            addend_d = A;
            state_d  = MUL;
          end else begin
            result_d = single_result;
            done_d   = 1'b1;
          end
        end
      end
      MUL: begin
        mul_step = 1'b1;
        if (mul_last) state_d = FIX;
      end
      FIX: begin
        result_d = mul_product + addend_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      addend_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      addend_q <= addend_d;
      zero_q   <= (result_d == '0);
      done_q   <= done_d;
    end
  end

  assign ALUResult = result_q;
  assign Zero      = zero_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule
